// File: rtl/control_sequencer_if.sv
// Instruction handshake bundle between an instruction source and control_sequencer.
//   instr        16-bit word {op[15:12], dst[11:10], src[9:8], imm[7:0]}
//   instr_valid  source holds a valid word (must stay stable until accepted)
//   instr_ready  sequencer accepts the word this cycle
// master: instruction source, slave: sequencer.
interface control_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: decodes 16-bit instruction words into timed DP control
// strobes with a registered IDLE/E1/E2 state machine.
// Ports:
//   clock, clear_n       clock (rising edge) and async active-low reset
//   in_if (slave)        instr / instr_valid / instr_ready handshake
//   RZout, RAout, RBout  drive Z/A/B onto the DP bus (at most one high)
//   RAin, RBin, RZin     latch the bus (or immediate) into A/B/Z
//   AddImmediate         adder addend, nonzero only with the ADDI E1 RZin
//   RegisterAImmediate   A load value, nonzero only with the LDI RAin
//   done                 pulse in the final exec cycle of every accepted word
//   illegal              pulse in the exec cycle of a dropped illegal word
//   instr_count          retired-word counter, present only when SEQ_PERF_EN is defined
// Optional feature macro: SEQ_PERF_EN
//
// state | meaning
// IDLE  | no word executing, ready for a new one
// E1    | first exec cycle (only cycle for NOP/LDI/MV/illegal)
// E2    | second exec cycle of ADDI (Z onto bus, write destination)
module control_sequencer #(
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  control_sequencer_if.slave in_if,
  output logic               RZout,
  output logic               RAout,
  output logic               RBout,
  output logic               RAin,
  output logic               RBin,
  output logic               RZin,
  output logic [IMM_W-1:0]   AddImmediate,
  output logic [IMM_W-1:0]   RegisterAImmediate,
  output logic               done,
  output logic               illegal
`ifdef SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   instr_count
`endif
);

  typedef enum logic [1:0] {IDLE, E1, E2} state_t;

  typedef struct packed {
    logic rz_out;
    logic ra_out;
    logic rb_out;
    logic ra_in;
    logic rb_in;
    logic rz_in;
  } strobe_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_MV   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;

  state_t           state_q, state_d;
  logic             addi_q, addi_d;
  logic [1:0]       dst_q, dst_d;
  strobe_t          strb_q, strb_d;
  logic [IMM_W-1:0] add_imm_q, add_imm_d;
  logic [IMM_W-1:0] ra_imm_q, ra_imm_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       op;
  logic [1:0]       dst, src;
  logic [IMM_W-1:0] imm;
  logic             legal;
  logic             last_cycle;
  logic             accept;

  function automatic strobe_t out_sel(input logic [1:0] code);
    strobe_t s;
    s = '0;
    case (code)
      2'd0:    s.ra_out = 1'b1;
      2'd1:    s.rb_out = 1'b1;
      2'd2:    s.rz_out = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic strobe_t in_sel(input logic [1:0] code);
    strobe_t s;
    s = '0;
    case (code)
      2'd0:    s.ra_in = 1'b1;
      2'd1:    s.rb_in = 1'b1;
      2'd2:    s.rz_in = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign op  = in_if.instr[15:12];
  assign dst = in_if.instr[11:10];
  assign src = in_if.instr[9:8];
  assign imm = in_if.instr[IMM_W-1:0];

  // Register code 3 is only illegal in fields the opcode actually uses.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_NOP, OP_LDI:  legal = 1'b1;
      OP_MV, OP_ADDI:  legal = (dst != 2'd3) && (src != 2'd3);
      default:         legal = 1'b0;
    endcase
  end

  assign last_cycle         = ((state_q == E1) && !addi_q) || (state_q == E2);
  assign in_if.instr_ready  = (state_q == IDLE) || last_cycle;
  assign accept             = in_if.instr_valid && in_if.instr_ready;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      addi_q    <= 1'b0;
      dst_q     <= '0;
      strb_q    <= '0;
      add_imm_q <= '0;
      ra_imm_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addi_q    <= addi_d;
      dst_q     <= dst_d;
      strb_q    <= strb_d;
      add_imm_q <= add_imm_d;
      ra_imm_q  <= ra_imm_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    addi_d  = addi_q;
    dst_d   = dst_q;
    if (accept) begin
      state_d = E1;
      addi_d  = legal && (op == OP_ADDI);
      dst_d   = dst;
    end else if ((state_q == E1) && addi_q) begin
      state_d = E2;
    end
  end

  // Outputs are computed one cycle ahead and registered, so strobes for an
  // accepted word appear in the cycle after acceptance.
  always_comb begin
    strb_d    = '0;
    add_imm_d = '0;
    ra_imm_d  = '0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    if (accept) begin
      if (!legal) begin
        illegal_d = 1'b1;
        done_d    = 1'b1;
      end else begin
        case (op)
          OP_LDI: begin
            strb_d.ra_in = 1'b1;
            ra_imm_d     = imm;
            done_d       = 1'b1;
          end
          OP_MV: begin
            strb_d = out_sel(src) | in_sel(dst);
            done_d = 1'b1;
          end
          OP_ADDI: begin
            strb_d       = out_sel(src);
            strb_d.rz_in = 1'b1;
            add_imm_d    = imm;
          end
          default: done_d = 1'b1;
        endcase
      end
    end else if ((state_q == E1) && addi_q) begin
      strb_d        = in_sel(dst_q);
      strb_d.rz_out = 1'b1;
      done_d        = 1'b1;
    end
  end

  assign RZout              = strb_q.rz_out;
  assign RAout              = strb_q.ra_out;
  assign RBout              = strb_q.rb_out;
  assign RAin               = strb_q.ra_in;
  assign RBin               = strb_q.rb_in;
  assign RZin               = strb_q.rz_in;
  assign AddImmediate       = add_imm_q;
  assign RegisterAImmediate = ra_imm_q;
  assign done               = done_q;
  assign illegal            = illegal_q;

`ifdef SEQ_PERF_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Counts in the cycle after the done pulse; wraps naturally.
  always_comb begin
    count_d = count_q + (done_q ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign instr_count = count_q;
`endif

endmodule
